// File: rtl/neo_cntout_master.sv
// Bus initiator for the coin counter/lockout register: a command FIFO feeding a
// SETUP/STROBE/HOLD write FSM. Define NEO_CNTOUT_PULSE_EN to build the coin pulse engine.
module neo_cntout_master #(
  parameter int SETUP_CYC = 2,
  parameter int STB_CYC   = 4,
  parameter int HOLD_CYC  = 1,
  parameter int PULSE_CYC = 16
) (
  input  logic       CLK_24M,
  input  logic       RESET,
  input  logic       REQ_VALID,
  input  logic [2:0] REQ_CMD,
  output logic       REQ_READY,
  input  logic [1:0] COIN_EVT,
  output logic [2:0] M68K_ADDR,
  output logic       M68K_ADDR_7,
  output logic       nCOUNTOUT,
  output logic       BUSY,
  output logic [3:0] SHADOW,
  output logic       PULSE_OVF
);

  localparam int MAX_SS  = (SETUP_CYC > STB_CYC) ? SETUP_CYC : STB_CYC;
  localparam int MAX_CYC = (MAX_SS > HOLD_CYC) ? MAX_SS : HOLD_CYC;
  localparam int CYC_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

  state_t           r_state;
  logic [CYC_W-1:0] r_cyc;
  logic [2:0]       r_addr;
  logic             r_data;
  logic             r_ncountout;
  logic [3:0]       r_shadow;
  logic             r_from_pulse;
  logic             r_pidx;

  logic [2:0]       r_fifo [4];
  logic [1:0]       r_wr_ptr;
  logic [1:0]       r_rd_ptr;
  logic [2:0]       r_count;

  logic             w_push;
  logic             w_pop;
  logic             w_start;
  logic             w_from_pulse;
  logic             w_pidx;
  logic             w_write_done;
  logic [2:0]       w_cmd;
  logic [1:0]       w_set_req;
  logic [1:0]       w_clr_req;

  assign REQ_READY    = (r_count < 3'd4);
  assign w_push       = REQ_VALID && REQ_READY;
  assign w_pop        = (r_state == S_IDLE) && (r_count != 3'd0);
  assign w_write_done = (r_state == S_HOLD) && (r_cyc == CYC_W'(HOLD_CYC - 1));

  assign M68K_ADDR   = r_addr;
  assign M68K_ADDR_7 = r_data;
  assign nCOUNTOUT   = r_ncountout;
  assign BUSY        = (r_state != S_IDLE);
  assign SHADOW      = r_shadow;

  // NOTE: storage needs no reset; r_count alone decides which entries are valid.
  always_ff @(posedge CLK_24M) begin
    if (w_push) r_fifo[r_wr_ptr] <= REQ_CMD;
  end

  always_ff @(posedge CLK_24M or posedge RESET) begin
    if (RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: ;
      endcase
    end
  end

  // Source priority: FIFO head, then pulse CLEARs, then pulse SETs (counter 1 first).
  always_comb begin
    w_start      = 1'b0;
    w_cmd        = 3'b000;
    w_from_pulse = 1'b0;
    w_pidx       = 1'b0;
    if (r_count != 3'd0) begin
      w_start = 1'b1;
      w_cmd   = r_fifo[r_rd_ptr];
    end else if (w_clr_req[0]) begin
      w_start = 1'b1; w_cmd = 3'b000; w_from_pulse = 1'b1; w_pidx = 1'b0;
    end else if (w_clr_req[1]) begin
      w_start = 1'b1; w_cmd = 3'b001; w_from_pulse = 1'b1; w_pidx = 1'b1;
    end else if (w_set_req[0]) begin
      w_start = 1'b1; w_cmd = 3'b100; w_from_pulse = 1'b1; w_pidx = 1'b0;
    end else if (w_set_req[1]) begin
      w_start = 1'b1; w_cmd = 3'b101; w_from_pulse = 1'b1; w_pidx = 1'b1;
    end
  end

  always_ff @(posedge CLK_24M or posedge RESET) begin
    if (RESET) begin
      r_state      <= S_IDLE;
      r_cyc        <= '0;
      r_addr       <= '0;
      r_data       <= 1'b0;
      r_ncountout  <= 1'b1;
      r_shadow     <= '0;
      r_from_pulse <= 1'b0;
      r_pidx       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state      <= S_SETUP;
            r_cyc        <= '0;
            r_addr       <= {1'b0, w_cmd[1:0]};
            r_data       <= w_cmd[2];
            r_from_pulse <= w_from_pulse;
            r_pidx       <= w_pidx;
          end
        end
        S_SETUP: begin
          if (r_cyc == CYC_W'(SETUP_CYC - 1)) begin
            r_state     <= S_STROBE;
            r_cyc       <= '0;
            r_ncountout <= 1'b0;
          end else begin
            r_cyc <= r_cyc + CYC_W'(1);
          end
        end
        S_STROBE: begin
          if (r_cyc == CYC_W'(STB_CYC - 1)) begin
            r_state                <= S_HOLD;
            r_cyc                  <= '0;
            r_ncountout            <= 1'b1;
            r_shadow[r_addr[1:0]]  <= r_data;
          end else begin
            r_cyc <= r_cyc + CYC_W'(1);
          end
        end
        S_HOLD: begin
          if (w_write_done) r_state <= S_IDLE;
          else              r_cyc   <= r_cyc + CYC_W'(1);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef NEO_CNTOUT_PULSE_EN
  localparam int                 TMR_W   = $clog2(PULSE_CYC + 1);
  localparam logic [TMR_W-1:0]   TMR_MAX = TMR_W'(PULSE_CYC - 1);

  typedef enum logic [1:0] {P_IDLE, P_SETW, P_TIMER, P_CLRW} pstate_t;

  pstate_t          r_pstate [2];
  logic [3:0]       r_pend   [2];
  logic [TMR_W-1:0] r_tmr    [2];
  logic             r_ovf;

  logic [1:0]       w_grant;
  logic [1:0]       w_pdone;
  logic [1:0]       w_dec;

  assign PULSE_OVF = r_ovf;

  // The timer saturates at TMR_MAX so a CLEAR waits patiently behind other traffic.
  always_comb begin
    w_set_req = 2'b00;
    w_clr_req = 2'b00;
    w_grant   = 2'b00;
    w_pdone   = 2'b00;
    w_dec     = 2'b00;
    for (int i = 0; i < 2; i++) begin
      w_set_req[i] = (r_pstate[i] == P_IDLE) && (r_pend[i] != 4'd0);
      w_clr_req[i] = (r_pstate[i] == P_TIMER) && (r_tmr[i] == TMR_MAX);
      w_grant[i]   = (r_state == S_IDLE) && w_start && w_from_pulse && (w_pidx == i[0]);
      w_pdone[i]   = w_write_done && r_from_pulse && (r_pidx == i[0]);
      w_dec[i]     = w_pdone[i] && (r_pstate[i] == P_CLRW);
    end
  end

  always_ff @(posedge CLK_24M or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 2; i++) begin
        r_pstate[i] <= P_IDLE;
        r_pend[i]   <= '0;
        r_tmr[i]    <= '0;
      end
      r_ovf <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        case (r_pstate[i])
          P_IDLE:  if (w_grant[i]) r_pstate[i] <= P_SETW;
          P_SETW: begin
            if (w_pdone[i]) begin
              r_pstate[i] <= P_TIMER;
              r_tmr[i]    <= '0;
            end
          end
          P_TIMER: begin
            if (w_grant[i])              r_pstate[i] <= P_CLRW;
            else if (r_tmr[i] != TMR_MAX) r_tmr[i]   <= r_tmr[i] + TMR_W'(1);
          end
          P_CLRW:  if (w_pdone[i]) r_pstate[i] <= P_IDLE;
          default: r_pstate[i] <= P_IDLE;
        endcase

        if (COIN_EVT[i] && !w_dec[i]) begin
          if (r_pend[i] == 4'hF) r_ovf     <= 1'b1;
          else                   r_pend[i] <= r_pend[i] + 4'd1;
        end else if (!COIN_EVT[i] && w_dec[i]) begin
          r_pend[i] <= r_pend[i] - 4'd1;
        end
      end
    end
  end
`else
  logic w_unused;

  assign w_set_req = 2'b00;
  assign w_clr_req = 2'b00;
  assign PULSE_OVF = 1'b0;
  assign w_unused  = ^{COIN_EVT, r_from_pulse, r_pidx, w_write_done} ^ (PULSE_CYC > 0);
`endif

endmodule

// File: tb/tb_neo_cntout_master.sv
// Directed bench for neo_cntout_master: strobe timing, FIFO ordering/backpressure,
// coin pulse engine (when NEO_CNTOUT_PULSE_EN is defined) and asynchronous reset.
module tb_neo_cntout_master;

  logic       CLK_24M   = 1'b0;
  logic       RESET     = 1'b1;
  logic       REQ_VALID = 1'b0;
  logic [2:0] REQ_CMD   = 3'b000;
  logic [1:0] COIN_EVT  = 2'b00;
  logic       REQ_READY;
  logic [2:0] M68K_ADDR;
  logic       M68K_ADDR_7;
  logic       nCOUNTOUT;
  logic       BUSY;
  logic [3:0] SHADOW;
  logic       PULSE_OVF;

  int n_checks = 0;
  int n_pass   = 0;

  neo_cntout_master dut (
    .CLK_24M     (CLK_24M),
    .RESET       (RESET),
    .REQ_VALID   (REQ_VALID),
    .REQ_CMD     (REQ_CMD),
    .REQ_READY   (REQ_READY),
    .COIN_EVT    (COIN_EVT),
    .M68K_ADDR   (M68K_ADDR),
    .M68K_ADDR_7 (M68K_ADDR_7),
    .nCOUNTOUT   (nCOUNTOUT),
    .BUSY        (BUSY),
    .SHADOW      (SHADOW),
    .PULSE_OVF   (PULSE_OVF)
  );

  always #5 CLK_24M = ~CLK_24M;

  // Strobe monitor: each strobe logged as {addr[2:0], data}, with high-gap and low-length.
  logic [3:0] st_q [$];
  int         gap_q [$];
  int         low_q [$];
  logic       m_prev     = 1'b1;
  int         m_run      = 0;
  logic [3:0] m_cur      = 4'h0;
  int         m_unstable = 0;

  always @(negedge CLK_24M) begin
    if (RESET) begin
      m_prev <= 1'b1;
      m_run  <= 0;
    end else begin
      if (m_prev && !nCOUNTOUT) begin
        st_q.push_back({M68K_ADDR, M68K_ADDR_7});
        gap_q.push_back(m_run);
        m_cur <= {M68K_ADDR, M68K_ADDR_7};
        m_run <= 1;
      end else if (!m_prev && nCOUNTOUT) begin
        low_q.push_back(m_run);
        m_run <= 1;
      end else begin
        m_run <= m_run + 1;
      end
      if (!m_prev && !nCOUNTOUT && (m_cur != {M68K_ADDR, M68K_ADDR_7}))
        m_unstable <= m_unstable + 1;
      m_prev <= nCOUNTOUT;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [3:0] st_at(input int i);
    return (i < st_q.size()) ? st_q[i] : 4'bxxxx;
  endfunction

  function automatic int low_at(input int i);
    return (i < low_q.size()) ? low_q[i] : -1;
  endfunction

  function automatic int gap_at(input int i);
    return (i < gap_q.size()) ? gap_q[i] : -1;
  endfunction

  function automatic int count_st(input int from, input logic [3:0] v);
    int n = 0;
    for (int i = from; i < st_q.size(); i++) if (st_q[i] == v) n++;
    return n;
  endfunction

  // Expected bus encoding of a command {data, sel}: {addr = {0, sel}, data}.
  function automatic logic [3:0] enc(input logic [2:0] cmd);
    return {1'b0, cmd[1:0], cmd[2]};
  endfunction

  task automatic push_one(input logic [2:0] cmd);
    @(negedge CLK_24M);
    REQ_VALID = 1'b1;
    REQ_CMD   = cmd;
    @(posedge CLK_24M);
    #1 REQ_VALID = 1'b0;
  endtask

  logic [3:0] shadow_seen;

  task automatic wait_quiet(input string tag, input int budget);
    int quiet = 0;
    int n = 0;
    while (quiet < 20 && n < budget) begin
      @(negedge CLK_24M);
      n++;
      shadow_seen = shadow_seen | SHADOW;
      quiet = BUSY ? 0 : quiet + 1;
    end
    if (quiet < 20) check({tag, "_timeout"}, 32'(quiet), 32'd20);
  endtask

  initial begin
    int         base;
    int         n;
    int         min_gap;
    int         low_ok;
    logic [8:0] busy_bits;
    logic [8:0] low_bits;
    logic [5:0] rdy_bits;
    logic [2:0] t1_addr;
    logic       t1_data;
    logic [3:0] t1_sh6;
    logic [2:0] cmds2 [5];
    logic [2:0] cmds5 [4];

    // Reset values
    repeat (3) @(posedge CLK_24M);
    @(negedge CLK_24M);
    RESET = 1'b0;
    check("rst_ncountout", nCOUNTOUT, 1);
    check("rst_addr", M68K_ADDR, 0);
    check("rst_addr7", M68K_ADDR_7, 0);
    check("rst_busy", BUSY, 0);
    check("rst_shadow", SHADOW, 0);
    check("rst_ovf", PULSE_OVF, 0);
    check("rst_ready", REQ_READY, 1);

    // 1: single write, exact cycle timing relative to acceptance edge n
    base = st_q.size();
    push_one(3'b110);
    busy_bits = '0;
    low_bits  = '0;
    t1_addr   = '0;
    t1_data   = 1'b0;
    t1_sh6    = '0;
    for (int k = 0; k < 9; k++) begin
      @(negedge CLK_24M);
      busy_bits[k] = BUSY;
      low_bits[k]  = ~nCOUNTOUT;
      if (k == 3) begin t1_addr = M68K_ADDR; t1_data = M68K_ADDR_7; end
      if (k == 6) t1_sh6 = SHADOW;
    end
    check("t1_busy_pattern", busy_bits, 9'h0FE);
    check("t1_strobe_pattern", low_bits, 9'h078);
    check("t1_addr", t1_addr, 3'b010);
    check("t1_data", t1_data, 1);
    check("t1_shadow_during", t1_sh6, 4'b0000);
    check("t1_shadow_after", SHADOW, 4'b0100);
    wait_quiet("t1", 200);
    check("t1_strobe_count", st_q.size() - base, 1);
    check("t1_low_len", low_at(base), 4);

    // 2: five back-to-back pushes; FIFO fills after the 5th since the 1st pops at once
    cmds2[0] = 3'b100; cmds2[1] = 3'b101; cmds2[2] = 3'b111;
    cmds2[3] = 3'b000; cmds2[4] = 3'b010;
    base = st_q.size();
    rdy_bits = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK_24M);
      REQ_VALID   = 1'b1;
      REQ_CMD     = cmds2[i];
      rdy_bits[i] = REQ_READY;
    end
    @(negedge CLK_24M);
    REQ_VALID   = 1'b0;
    rdy_bits[5] = REQ_READY;
    check("t2_ready_seq", rdy_bits, 6'b011111);
    wait_quiet("t2", 400);
    check("t2_strobe_count", st_q.size() - base, 5);
    min_gap = 1000;
    low_ok  = 0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t2_order%0d", i), st_at(base + i), enc(cmds2[i]));
      if (low_at(base + i) == 4) low_ok++;
      if (i > 0 && gap_at(base + i) < min_gap) min_gap = gap_at(base + i);
    end
    check("t2_low_lens", low_ok, 5);
    check("t2_min_gap", min_gap, 4);
    check("t2_shadow", SHADOW, 4'b1010);
    check("t2_addr_stable", m_unstable, 0);

`ifdef NEO_CNTOUT_PULSE_EN
    // 3: one coin on counter 1 -> SET, 16 idle cycles, CLEAR
    base = st_q.size();
    shadow_seen = '0;
    @(negedge CLK_24M); COIN_EVT = 2'b01;
    @(negedge CLK_24M); COIN_EVT = 2'b00;
    wait_quiet("t3", 400);
    check("t3_strobe_count", st_q.size() - base, 2);
    check("t3_set", st_at(base), 4'b0001);
    check("t3_clear", st_at(base + 1), 4'b0000);
    check("t3_pulse_gap", gap_at(base + 1), 19);
    check("t3_shadow0_seen", shadow_seen[0], 1);
    check("t3_shadow", SHADOW, 4'b1010);

    // 4: both coins at once -> counter 1 SET first, one pulse each
    base = st_q.size();
    @(negedge CLK_24M); COIN_EVT = 2'b11;
    @(negedge CLK_24M); COIN_EVT = 2'b00;
    wait_quiet("t4", 400);
    check("t4_strobe_count", st_q.size() - base, 4);
    check("t4_seq", {st_at(base), st_at(base + 1), st_at(base + 2), st_at(base + 3)},
          16'h1302);
    check("t4_ovf", PULSE_OVF, 0);

    // 5: 16 coins on counter 2 while FIFO traffic holds the FSM busy
    cmds5[0] = 3'b110; cmds5[1] = 3'b011; cmds5[2] = 3'b111; cmds5[3] = 3'b010;
    base = st_q.size();
    for (int i = 0; i < 4; i++) push_one(cmds5[i]);
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK_24M); COIN_EVT = 2'b10;
    end
    @(negedge CLK_24M); COIN_EVT = 2'b00;
    check("t5_ovf", PULSE_OVF, 1);
    wait_quiet("t5", 4000);
    check("t5_set_pulses", count_st(base, 4'b0011), 15);
    check("t5_clr_pulses", count_st(base, 4'b0010), 15);
    check("t5_strobe_count", st_q.size() - base, 34);
    check("t5_fifo_first", st_at(base), enc(cmds5[0]));
    check("t5_shadow", SHADOW, 4'b1000);
    check("t5_addr_stable", m_unstable, 0);
`else
    // Pulse engine absent: coin events must be ignored
    base = st_q.size();
    @(negedge CLK_24M); COIN_EVT = 2'b11;
    repeat (20) @(negedge CLK_24M);
    COIN_EVT = 2'b00;
    repeat (40) @(negedge CLK_24M);
    check("nopulse_strobes", st_q.size() - base, 0);
    check("nopulse_ovf", PULSE_OVF, 0);
    check("nopulse_shadow", SHADOW, 4'b1010);
`endif

    // 6: asynchronous reset in the middle of a strobe discards all work
`ifdef NEO_CNTOUT_PULSE_EN
    @(negedge CLK_24M); COIN_EVT = 2'b01;
    @(negedge CLK_24M); COIN_EVT = 2'b00;
`endif
    push_one(3'b101);
    push_one(3'b111);
    push_one(3'b100);
    n = 0;
    while (nCOUNTOUT !== 1'b0 && n < 40) begin
      @(negedge CLK_24M);
      n++;
    end
    check("t6_in_strobe", nCOUNTOUT, 0);
    #2 RESET = 1'b1;
    #1;
    check("t6_async_ncountout", nCOUNTOUT, 1);
    check("t6_async_busy", BUSY, 0);
    repeat (2) @(posedge CLK_24M);
    @(negedge CLK_24M);
    RESET = 1'b0;
    base = st_q.size();
    repeat (100) @(negedge CLK_24M);
    check("t6_no_strobes", st_q.size() - base, 0);
    check("t6_shadow", SHADOW, 0);
    check("t6_busy", BUSY, 0);
    check("t6_ready", REQ_READY, 1);
    check("t6_ovf", PULSE_OVF, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
